// File: rtl/multicycle_controller_if.sv
// rtl/multicycle_controller_if.sv - control/handshake bundle between the multi-cycle controller and the datapath
//
// Purpose: groups the IR fields, ALU flag, memory handshake and all datapath
// control selects/enables into one interface.
// Ports (signals):
//   i_operand[6:0], i_funct3[2:0], i_funct7bit5 : IR fields seen by the controller
//   i_zero                                       : ALU zero flag
//   i_memReady                                   : memory completes pending request
//   o_memReq, o_memWrite, o_adrSrc               : memory request, direction, address select
//   o_irWrite, o_pcWrite, o_regWrite             : state-element write enables
//   o_aluSrcA, o_aluSrcB, o_resultSrc, o_immSrc  : datapath mux selects
//   o_aluLogicOperation[3:0]                     : ALU operation
//   o_illegal                                    : unsupported-instruction pulse
// Modports: master = controller side, slave = datapath/memory side.
interface multicycle_controller_if;
    logic [6:0] i_operand;
    logic [2:0] i_funct3;
    logic       i_funct7bit5;
    logic       i_zero;
    logic       i_memReady;
    logic       o_memReq;
    logic       o_memWrite;
    logic       o_adrSrc;
    logic       o_irWrite;
    logic       o_pcWrite;
    logic       o_regWrite;
    logic [1:0] o_aluSrcA;
    logic [1:0] o_aluSrcB;
    logic [1:0] o_resultSrc;
    logic [1:0] o_immSrc;
    logic [3:0] o_aluLogicOperation;
    logic       o_illegal;

    modport master (
        input  i_operand, i_funct3, i_funct7bit5, i_zero, i_memReady,
        output o_memReq, o_memWrite, o_adrSrc, o_irWrite, o_pcWrite, o_regWrite,
               o_aluSrcA, o_aluSrcB, o_resultSrc, o_immSrc, o_aluLogicOperation, o_illegal
    );

    modport slave (
        output i_operand, i_funct3, i_funct7bit5, i_zero, i_memReady,
        input  o_memReq, o_memWrite, o_adrSrc, o_irWrite, o_pcWrite, o_regWrite,
               o_aluSrcA, o_aluSrcB, o_resultSrc, o_immSrc, o_aluLogicOperation, o_illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// rtl/multicycle_controller.sv - main control FSM of the multi-cycle RV32I core
//
// Purpose: sequences the shared datapath through fetch/decode/execute/memory/
// writeback, one step per cycle, stalling on the memory ready handshake.
// Ports:
//   i_clk    : core clock, rising edge
//   i_arst_n : asynchronous active-low reset; write enables and memory request
//              are forced low while it is asserted
//   bus      : multicycle_controller_if.master (IR fields, flags, handshake, controls)
module multicycle_controller (
    input  logic                         i_clk,
    input  logic                         i_arst_n,
    multicycle_controller_if.master      bus
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECUTER, EXECUTEI, ALUWB, BEQ, JAL
    } state_t;

    state_t state_q, state_d;

    // Raw (ungated) enables; reset masking is applied at the outputs.
    logic       mem_req, mem_write, ir_write, pc_write, reg_write, illegal;
    logic       adr_src;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [3:0] alu_op;

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        illegal    = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        alu_op     = 4'b0000;

        case (state_q)
            FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                // PC+4 and the IR load both commit in the completing cycle.
                ir_write   = bus.i_memReady;
                pc_write   = bus.i_memReady;
                if (bus.i_memReady) state_d = DECODE;
            end
            DECODE: begin
                // Precompute the branch/jump target into ALUOut.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (bus.i_operand)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTER;
                    OP_I:         state_d = EXECUTEI;
                    OP_JAL:       state_d = JAL;
                    OP_BEQ: begin
                        if (bus.i_funct3 == 3'b000) begin
                            state_d = BEQ;
                        end else begin
                            illegal = 1'b1;
                            state_d = FETCH;
                        end
                    end
                    default: begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (bus.i_operand == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (bus.i_memReady) state_d = MEMWB;
            end
            MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                state_d    = FETCH;
            end
            MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (bus.i_memReady) state_d = FETCH;
            end
            EXECUTER: begin
                alu_src_a = 2'b10;
                alu_op    = {bus.i_funct7bit5, bus.i_funct3};
                state_d   = ALUWB;
            end
            EXECUTEI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                // Bit 30 is part of the immediate except for the shift-right pair.
                alu_op    = (bus.i_funct3 == 3'b101) ? {bus.i_funct7bit5, bus.i_funct3}
                                                     : {1'b0, bus.i_funct3};
                state_d   = ALUWB;
            end
            ALUWB: begin
                reg_write = 1'b1;
                state_d   = FETCH;
            end
            BEQ: begin
                alu_src_a = 2'b10;
                alu_op    = 4'b1000;
                pc_write  = bus.i_zero;
                state_d   = FETCH;
            end
            JAL: begin
                // PC takes the target from ALUOut while the ALU forms oldPC+4 for rd.
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
                state_d   = ALUWB;
            end
            default: begin
                state_d = FETCH;
            end
        endcase
    end

    always_comb begin
        case (bus.i_operand)
            OP_SW:   bus.o_immSrc = 2'b01;
            OP_BEQ:  bus.o_immSrc = 2'b10;
            OP_JAL:  bus.o_immSrc = 2'b11;
            default: bus.o_immSrc = 2'b00;
        endcase
    end

    // Enables are masked by reset so nothing writes between reset assertion
    // and the first edge after release.
    assign bus.o_memReq            = mem_req   & i_arst_n;
    assign bus.o_memWrite          = mem_write & i_arst_n;
    assign bus.o_irWrite           = ir_write  & i_arst_n;
    assign bus.o_pcWrite           = pc_write  & i_arst_n;
    assign bus.o_regWrite          = reg_write & i_arst_n;
    assign bus.o_illegal           = illegal   & i_arst_n;
    assign bus.o_adrSrc            = adr_src;
    assign bus.o_aluSrcA           = alu_src_a;
    assign bus.o_aluSrcB           = alu_src_b;
    assign bus.o_resultSrc         = result_src;
    assign bus.o_aluLogicOperation = alu_op;

endmodule

// File: tb/tb_multicycle_controller.sv
// tb/tb_multicycle_controller.sv - self-checking bench for multicycle_controller
module tb_multicycle_controller;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    // Step kinds of an instruction's life, used only to build expectations.
    localparam int K_FETCH = 0, K_DECODE = 1, K_MEMADR = 2, K_MEMREAD = 3, K_MEMWB = 4,
                   K_MEMWRITE = 5, K_EXR = 6, K_EXI = 7, K_ALUWB = 8, K_BEQ = 9,
                   K_JAL = 10, K_RESET = 11;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    logic [18:0] exp_vec;
    logic        exp_valid;
    logic [18:0] dut_vec;

    multicycle_controller_if bus ();

    multicycle_controller dut (
        .i_clk    (clk),
        .i_arst_n (rst_n),
        .bus      (bus)
    );

    // Layout: {memReq,memWrite,adrSrc,irWrite,pcWrite,regWrite,aluSrcA,aluSrcB,resultSrc,immSrc,aluOp,illegal}
    assign dut_vec = {bus.o_memReq, bus.o_memWrite, bus.o_adrSrc, bus.o_irWrite, bus.o_pcWrite,
                      bus.o_regWrite, bus.o_aluSrcA, bus.o_aluSrcB, bus.o_resultSrc, bus.o_immSrc,
                      bus.o_aluLogicOperation, bus.o_illegal};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic is_legal(logic [6:0] opd, logic [2:0] f3);
        return (opd == OP_LW) || (opd == OP_SW) || (opd == OP_R) || (opd == OP_I) ||
               (opd == OP_JAL) || ((opd == OP_BEQ) && (f3 == 3'b000));
    endfunction

    function automatic logic [18:0] model(int kind, logic [6:0] opd, logic [2:0] f3,
                                          logic b5, logic z, logic rdy);
        logic req, wr, adr, ir, pc, rw, ill;
        logic [1:0] a, b, r, imm;
        logic [3:0] op;
        req = 0; wr = 0; adr = 0; ir = 0; pc = 0; rw = 0; ill = 0;
        a = 2'b00; b = 2'b00; r = 2'b00; op = 4'b0000;
        imm = (opd == OP_SW) ? 2'b01 : (opd == OP_BEQ) ? 2'b10 : (opd == OP_JAL) ? 2'b11 : 2'b00;
        case (kind)
            K_FETCH:    begin req = 1; b = 2'b10; r = 2'b10; ir = rdy; pc = rdy; end
            K_DECODE:   begin a = 2'b01; b = 2'b01; ill = !is_legal(opd, f3); end
            K_MEMADR:   begin a = 2'b10; b = 2'b01; end
            K_MEMREAD:  begin req = 1; adr = 1; end
            K_MEMWB:    begin r = 2'b01; rw = 1; end
            K_MEMWRITE: begin req = 1; wr = 1; adr = 1; end
            K_EXR:      begin a = 2'b10; op = {b5, f3}; end
            K_EXI:      begin a = 2'b10; b = 2'b01; op = (f3 == 3'b101) ? {b5, f3} : {1'b0, f3}; end
            K_ALUWB:    begin rw = 1; end
            K_BEQ:      begin a = 2'b10; op = 4'b1000; pc = z; end
            K_JAL:      begin a = 2'b01; b = 2'b10; pc = 1; end
            default:    begin b = 2'b10; r = 2'b10; end
        endcase
        return {req, wr, adr, ir, pc, rw, a, b, r, imm, op, ill};
    endfunction

    // Every cycle with a defined expectation is checked here.
    always @(negedge clk) begin
        if (exp_valid) begin
            checks++;
            if (dut_vec !== exp_vec) begin
                failures++;
                $display("FAIL cycle_outputs t=%0t got=%b exp=%b", $time, dut_vec, exp_vec);
            end
        end
    end

    task automatic drive(int kind, logic [6:0] opd, logic [2:0] f3, logic b5, logic z, logic rdy);
        bus.i_operand    = opd;
        bus.i_funct3     = f3;
        bus.i_funct7bit5 = b5;
        bus.i_zero       = z;
        bus.i_memReady   = rdy;
        exp_vec          = model(kind, opd, f3, b5, z, rdy);
        exp_valid        = 1'b1;
    endtask

    task automatic step(int kind, logic [6:0] opd, logic [2:0] f3, logic b5, logic z, logic rdy);
        drive(kind, opd, f3, b5, z, rdy);
        @(posedge clk); #1;
    endtask

    task automatic lit_check(string nm, logic [18:0] lit);
        checks++;
        if (dut_vec !== lit) begin
            failures++;
            $display("FAIL %s got=%b exp=%b", nm, dut_vec, lit);
        end
    endtask

    // Step with an additional hand-computed literal expectation.
    task automatic pstep(string nm, logic [18:0] lit, int kind, logic [6:0] opd,
                         logic [2:0] f3, logic b5, logic z, logic rdy);
        drive(kind, opd, f3, b5, z, rdy);
        #3;
        lit_check(nm, lit);
        @(posedge clk); #1;
    endtask

    function automatic logic rb();
        return 1'($urandom);
    endfunction

    task automatic run_instr(logic [6:0] opd, logic [2:0] f3, logic b5, logic z, int wf, int wm);
        for (int w = 0; w <= wf; w++)
            step(K_FETCH, 7'($urandom), 3'($urandom), rb(), rb(), w == wf);
        step(K_DECODE, opd, f3, b5, rb(), rb());
        if (opd == OP_LW) begin
            step(K_MEMADR, opd, f3, b5, rb(), rb());
            for (int w = 0; w <= wm; w++) step(K_MEMREAD, opd, f3, b5, rb(), w == wm);
            step(K_MEMWB, opd, f3, b5, rb(), rb());
        end else if (opd == OP_SW) begin
            step(K_MEMADR, opd, f3, b5, rb(), rb());
            for (int w = 0; w <= wm; w++) step(K_MEMWRITE, opd, f3, b5, rb(), w == wm);
        end else if (opd == OP_R) begin
            step(K_EXR, opd, f3, b5, rb(), rb());
            step(K_ALUWB, opd, f3, b5, rb(), rb());
        end else if (opd == OP_I) begin
            step(K_EXI, opd, f3, b5, rb(), rb());
            step(K_ALUWB, opd, f3, b5, rb(), rb());
        end else if (opd == OP_BEQ && f3 == 3'b000) begin
            step(K_BEQ, opd, f3, b5, z, rb());
        end else if (opd == OP_JAL) begin
            step(K_JAL, opd, f3, b5, rb(), rb());
            step(K_ALUWB, opd, f3, b5, rb(), rb());
        end
    endtask

    initial begin
        logic [6:0] opd;
        logic [2:0] f3;
        int k;
        checks    = 0;
        failures  = 0;
        exp_valid = 1'b0;
        exp_vec   = '0;
        rst_n     = 1'b0;
        drive(K_RESET, OP_LW, 3'b000, 1'b0, 1'b1, 1'b1);
        #3;
        lit_check("reset_state", 19'b000000_00_10_10_00_0000_0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // lw, zero-wait memory: writeback only in cycle 5
        pstep("lw_fetch", 19'b100110_00_10_10_00_0000_0, K_FETCH, OP_LW, 3'b010, 1'b0, 1'b0, 1'b1);
        step(K_DECODE, OP_LW, 3'b010, 1'b0, 1'b0, 1'b0);
        step(K_MEMADR, OP_LW, 3'b010, 1'b0, 1'b0, 1'b0);
        step(K_MEMREAD, OP_LW, 3'b010, 1'b0, 1'b0, 1'b1);
        pstep("lw_memwb", 19'b000001_00_00_01_00_0000_0, K_MEMWB, OP_LW, 3'b010, 1'b0, 1'b0, 1'b0);

        // sw, memory stalls 3 cycles in MEMWRITE
        step(K_FETCH, OP_SW, 3'b010, 1'b0, 1'b0, 1'b1);
        step(K_DECODE, OP_SW, 3'b010, 1'b0, 1'b0, 1'b0);
        step(K_MEMADR, OP_SW, 3'b010, 1'b0, 1'b0, 1'b0);
        for (int w = 0; w < 4; w++)
            pstep("sw_hold", 19'b111000_00_00_00_01_0000_0, K_MEMWRITE, OP_SW, 3'b010, 1'b0, 1'b1, w == 3);

        // R-type sub
        step(K_FETCH, OP_R, 3'b000, 1'b1, 1'b0, 1'b1);
        step(K_DECODE, OP_R, 3'b000, 1'b1, 1'b0, 1'b0);
        pstep("r_sub", 19'b000000_10_00_00_00_1000_0, K_EXR, OP_R, 3'b000, 1'b1, 1'b0, 1'b0);
        pstep("r_aluwb", 19'b000001_00_00_00_00_0000_0, K_ALUWB, OP_R, 3'b000, 1'b1, 1'b0, 1'b0);

        // srai and addi with bit30 set
        run_instr(OP_I, 3'b101, 1'b1, 1'b0, 0, 0);
        step(K_FETCH, OP_I, 3'b101, 1'b1, 1'b0, 1'b1);
        step(K_DECODE, OP_I, 3'b101, 1'b1, 1'b0, 1'b0);
        pstep("i_srai", 19'b000000_10_01_00_00_1101_0, K_EXI, OP_I, 3'b101, 1'b1, 1'b0, 1'b0);
        step(K_ALUWB, OP_I, 3'b101, 1'b1, 1'b0, 1'b0);
        step(K_FETCH, OP_I, 3'b000, 1'b1, 1'b0, 1'b1);
        step(K_DECODE, OP_I, 3'b000, 1'b1, 1'b0, 1'b0);
        pstep("i_addi", 19'b000000_10_01_00_00_0000_0, K_EXI, OP_I, 3'b000, 1'b1, 1'b0, 1'b0);
        step(K_ALUWB, OP_I, 3'b000, 1'b1, 1'b0, 1'b0);

        // beq taken / not taken
        for (int t = 1; t >= 0; t--) begin
            step(K_FETCH, OP_BEQ, 3'b000, 1'b0, 1'b0, 1'b1);
            step(K_DECODE, OP_BEQ, 3'b000, 1'b0, 1'b0, 1'b0);
            pstep(t ? "beq_taken" : "beq_not_taken",
                  t ? 19'b000010_10_00_00_10_1000_0 : 19'b000000_10_00_00_10_1000_0,
                  K_BEQ, OP_BEQ, 3'b000, 1'b0, 1'(t), 1'b0);
        end

        // unsupported opcode
        step(K_FETCH, 7'b0110111, 3'b000, 1'b0, 1'b0, 1'b1);
        pstep("illegal_decode", 19'b000000_01_01_00_00_0000_1, K_DECODE, 7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0);
        pstep("illegal_refetch", 19'b100000_00_10_10_00_0000_0, K_FETCH, 7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0);
        step(K_FETCH, OP_R, 3'b000, 1'b0, 1'b0, 1'b1);
        step(K_DECODE, OP_R, 3'b000, 1'b0, 1'b0, 1'b0);
        step(K_EXR, OP_R, 3'b000, 1'b0, 1'b0, 1'b0);
        step(K_ALUWB, OP_R, 3'b000, 1'b0, 1'b0, 1'b0);

        // reset asserted inside MEMREAD with ready held high
        step(K_FETCH, OP_LW, 3'b010, 1'b0, 1'b0, 1'b1);
        step(K_DECODE, OP_LW, 3'b010, 1'b0, 1'b0, 1'b0);
        step(K_MEMADR, OP_LW, 3'b010, 1'b0, 1'b0, 1'b0);
        drive(K_MEMREAD, OP_LW, 3'b010, 1'b0, 1'b0, 1'b0);
        #6;
        bus.i_memReady = 1'b1;
        rst_n = 1'b0;
        #1;
        lit_check("reset_async", 19'b000000_00_10_10_00_0000_0);
        exp_vec = model(K_RESET, OP_LW, 3'b010, 1'b0, 1'b0, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;
        pstep("reset_release", 19'b100000_00_10_10_00_0000_0, K_FETCH, OP_LW, 3'b010, 1'b0, 1'b0, 1'b0);

        // randomized instruction stream
        for (int n = 0; n < 250; n++) begin
            k  = $urandom_range(0, 7);
            f3 = 3'($urandom);
            case (k)
                0: opd = OP_LW;
                1: opd = OP_SW;
                2: opd = OP_R;
                3: opd = OP_I;
                4: begin opd = OP_BEQ; f3 = 3'b000; end
                5: opd = OP_JAL;
                6: begin
                    opd = 7'($urandom);
                    while (is_legal(opd, f3) || opd == OP_BEQ) opd = 7'($urandom);
                end
                default: opd = OP_BEQ;
            endcase
            run_instr(opd, f3, rb(), rb(), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        exp_valid = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Main control FSM for the multi-cycle RV32I core. It sequences the shared datapath (one memory port, one ALU, register file, PC, IR, ALUOut and Data registers) through fetch, decode, execute, memory and writeback steps, one step per cycle. It stalls on a memory ready handshake. It replaces the purely combinational single-cycle decoder when the core moves to a shared memory and a single ALU.

## Interface
Parameters: none.

Ports (clock and reset first):
- i_clk  input  1  core clock; all state changes on rising edge.
- i_arst_n  input  1  asynchronous, active-low reset.
- i_operand  input  7  opcode field of IR (instr[6:0]).
- i_funct3  input  3  IR funct3.
- i_funct7bit5  input  1  IR bit 30.
- i_zero  input  1  ALU zero flag (current-cycle ALU result).
- i_memReady  input  1  memory completes the pending request this cycle.
- o_memReq  output  1  memory request valid; held until i_memReady.
- o_memWrite  output  1  request is a write (qualified by o_memReq).
- o_adrSrc  output  1  memory address: 0 = PC, 1 = ALUOut.
- o_irWrite  output  1  load IR and oldPC.
- o_pcWrite  output  1  load PC from result mux.
- o_regWrite  output  1  register file write enable.
- o_aluSrcA  output  2  00 PC, 01 oldPC, 10 rs1 register.
- o_aluSrcB  output  2  00 rs2 register, 01 immediate, 10 constant 4.
- o_resultSrc  output  2  00 ALUOut, 01 Data register, 10 ALU result.
- o_immSrc  output  2  00 I, 01 S, 10 B, 11 J.
- o_aluLogicOperation  output  4  ALU operation; 0000 add, 1000 sub, else {funct7bit5, funct3}.
- o_illegal  output  1  one-cycle pulse on an unsupported opcode.

## Operation
- Opcodes: lw 0000011, sw 0100011, R 0110011, I-ALU 0010011, beq 1100011, jal 1101111.
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BEQ, JAL.
- Outputs are a Moore decode of the state, except where noted. Every enable not listed for a state is 0. Unlisted mux selects are 00 and the ALU op is add.

State outputs and transitions:
- FETCH
  - Outputs: o_memReq=1, o_adrSrc=0, aluSrcA=00, aluSrcB=10, add, resultSrc=10.
  - o_irWrite and o_pcWrite equal i_memReady (Mealy).
  - Transition: to DECODE when i_memReady, else stay.
- DECODE
  - Outputs: aluSrcA=01, aluSrcB=01, add (branch target into ALUOut).
  - Transitions: lw/sw to MEMADR, R to EXECUTER, I to EXECUTEI, beq to BEQ, jal to JAL.
  - Any other opcode: pulse o_illegal and go to FETCH with no state writes.
- MEMADR
  - Outputs: aluSrcA=10, aluSrcB=01, add.
  - Transition: to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD
  - Outputs: o_memReq=1, o_adrSrc=1.
  - Transition: to MEMWB on i_memReady.
- MEMWB
  - Outputs: resultSrc=01, o_regWrite=1.
  - Transition: to FETCH.
- MEMWRITE
  - Outputs: o_memReq=1, o_memWrite=1, o_adrSrc=1.
  - Transition: to FETCH on i_memReady.
- EXECUTER
  - Outputs: aluSrcA=10, aluSrcB=00, op={funct7bit5, funct3}.
  - Transition: to ALUWB.
- EXECUTEI
  - Outputs: aluSrcA=10, aluSrcB=01.
  - ALU op is {0, funct3}, except funct3=101, which uses {funct7bit5, funct3}.
  - Transition: to ALUWB.
- ALUWB
  - Outputs: resultSrc=00, o_regWrite=1.
  - Transition: to FETCH.
- BEQ
  - Outputs: aluSrcA=10, aluSrcB=00, op=1000, resultSrc=00.
  - o_pcWrite equals i_zero (Mealy).
  - Transition: to FETCH.
- JAL
  - Outputs: aluSrcA=01, aluSrcB=10, add, resultSrc=00, o_pcWrite=1.
  - Transition: to ALUWB (rd gets oldPC+4).

Other rules:
- o_immSrc is decoded from i_operand in every state: lw/I 00, sw 01, beq 10, jal 11, other 00.
- Only funct3=000 is a valid beq; other branch funct3 values are illegal. o_illegal pulses in DECODE.

## Timing
Reset:
- Asynchronous assert: state becomes FETCH immediately.
- While i_arst_n=0, o_memReq, o_memWrite, o_irWrite, o_pcWrite, o_regWrite and o_illegal are forced to 0. Selects take their FETCH values.
- Release is synchronous to i_clk. FETCH begins on the first edge after release.

Latency in cycles, with memory ready on first request:
- lw 5, sw 4, R 4, I 4, jal 4, beq 3.
- Illegal opcode: 2 (FETCH, DECODE).
- Each memory wait cycle adds 1.

Handshake:
- o_memReq stays high and the address/select outputs are stable until i_memReady is sampled high.
- No new request is issued in the cycle after completion unless the next state requests one.
- i_memReady while o_memReq=0 is ignored.

Mid-operation events:
- Reset mid-instruction abandons the instruction. No write enable asserts after reset assertion.
- In MEMREAD, MEMWRITE and FETCH, only i_memReady advances the state. i_zero is ignored everywhere except BEQ.

## Test plan
- Reset mid-operation: reset in MEMREAD with i_memReady=1 held -> all enables 0 immediately; state is FETCH and o_memReq=1 on the first cycle after release.
- lw with zero-wait memory (opcode 0000011) -> states FETCH→DECODE→MEMADR→MEMREAD→MEMWB→FETCH. o_regWrite=1 with resultSrc=01 only in cycle 5; o_immSrc=00.
- sw with memory stalling 3 cycles in MEMWRITE -> o_memReq=o_memWrite=o_adrSrc=1 held for 4 cycles, then FETCH. o_regWrite never asserts.
- R-type sub (funct7bit5=1, funct3=000) -> o_aluLogicOperation=1000 in EXECUTER. Then ALUWB with o_regWrite=1.
- I-type srai (funct3=101, bit30=1) -> op 1101. The same case with addi (funct3=000, bit30=1) -> op 0000.
- beq:
  - i_zero=1 in BEQ -> o_pcWrite=1 for one cycle.
  - i_zero=0 -> o_pcWrite=0.
  - Both cases return to FETCH after 3 cycles.
- Opcode 0110111 -> o_illegal=1 in DECODE for exactly one cycle, no writes, back to FETCH.
